// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
package regfile_pkg;

    localparam int NUM_REGS         = 32;
    localparam int IDX_W            = 5;
    localparam int DATA_W           = 16;
    localparam int STARVE_LIMIT_DEF = 3;

    // Width of each per-register pending-write count
    localparam int PEND_W = 2;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    // One writeback request as seen by the write-port mux
    typedef struct packed {
        logic              valid;
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_scheduler_wb_port_arbiter.sv
// Two-way writeback arbiter: mem normally wins, but an ALU request that has
// lost STARVE_LIMIT consecutive cycles is granted next.
module wb_port_arbiter
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic alu_valid,
    input  logic mem_valid,
    output logic alu_grant,
    output logic mem_grant
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             starve_hit;

    // Single-winner grant; the starved ALU overrides the default mem priority
    always_comb begin
        alu_grant  = 1'b0;
        mem_grant  = 1'b0;
        starve_hit = (starve_cnt == LIMIT_C);
        if (alu_valid && (!mem_valid || starve_hit)) begin
            alu_grant = 1'b1;
        end else if (mem_valid) begin
            mem_grant = 1'b1;
        end
    end

    // Count consecutive lost ALU cycles, saturating at the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!alu_valid || alu_grant) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT_C) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler: shares the single write port between the
// ALU and load paths and tracks pending writes per register for decode hazards.
module regfile_wb_scheduler
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [IDX_W-1:0]    issue_dest,
    input  logic                src_check,
    input  logic [IDX_W-1:0]    src1_idx,
    input  logic [IDX_W-1:0]    src2_idx,
    output logic                hazard_stall,
    input  logic                alu_wb_valid,
    input  logic [IDX_W-1:0]    alu_wb_idx,
    input  logic [DATA_W-1:0]   alu_wb_data,
    output logic                alu_wb_ready,
    input  logic                mem_wb_valid,
    input  logic [IDX_W-1:0]    mem_wb_idx,
    input  logic [DATA_W-1:0]   mem_wb_data,
    output logic                mem_wb_ready,
    output logic                rf_we,
    output logic [IDX_W-1:0]    rf_write_index,
    output logic [DATA_W-1:0]   rf_write_data,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                err_unexpected_wb
);

    logic alu_grant;
    logic mem_grant;

    wb_req_t alu_req;
    wb_req_t mem_req;
    wb_req_t win_req;

    logic [PEND_W-1:0]   pending [NUM_REGS];
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic                issue_accept;
    logic                commit_to_idle;

    wb_port_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arbiter (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_wb_valid),
        .mem_valid (mem_wb_valid),
        .alu_grant (alu_grant),
        .mem_grant (mem_grant)
    );

    assign alu_wb_ready = alu_grant;
    assign mem_wb_ready = mem_grant;

    // Select the granted request for the write-port register
    always_comb begin
        alu_req = '{valid: alu_wb_valid, idx: alu_wb_idx, data: alu_wb_data};
        mem_req = '{valid: mem_wb_valid, idx: mem_wb_idx, data: mem_wb_data};
        win_req = '0;
        if (mem_grant) begin
            win_req = mem_req;
        end else if (alu_grant) begin
            win_req = alu_req;
        end
    end

    // Register the winner so the register file sees it one cycle after the handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we          <= 1'b0;
            rf_write_index <= '0;
            rf_write_data  <= '0;
        end else begin
            rf_we <= win_req.valid;
            if (win_req.valid) begin
                rf_write_index <= win_req.idx;
                rf_write_data  <= win_req.data;
            end
        end
    end

    // Decode hazards: RAW on either source, or a destination whose count is full
    always_comb begin
        hazard_stall = 1'b0;
        if (src_check && ((pending[src1_idx] != '0) || (pending[src2_idx] != '0))) begin
            hazard_stall = 1'b1;
        end
        if (issue_valid && (pending[issue_dest] == PEND_MAX)) begin
            hazard_stall = 1'b1;
        end
    end

    assign issue_accept   = issue_valid && !hazard_stall;
    assign commit_to_idle = rf_we && (pending[rf_write_index] == '0);

    // Per-register increment/decrement requests; a commit to an idle register never decrements
    always_comb begin
        inc_vec  = '0;
        dec_vec  = '0;
        busy_vec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            inc_vec[i]  = issue_accept && (issue_dest == IDX_W'(i));
            dec_vec[i]  = rf_we && (rf_write_index == IDX_W'(i)) && (pending[i] != '0);
            busy_vec[i] = (pending[i] != '0);
        end
    end

    // Pending-write counts; a simultaneous increment and decrement cancel out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                pending[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    pending[i] <= pending[i] + PEND_W'(1);
                end else if (dec_vec[i] && !inc_vec[i]) begin
                    pending[i] <= pending[i] - PEND_W'(1);
                end
            end
        end
    end

    // Sticky flag for a write that nobody was waiting for
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_unexpected_wb <= 1'b0;
        end else if (commit_to_idle) begin
            err_unexpected_wb <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench for regfile_wb_scheduler: directed scenarios then random traffic.
module tb_regfile_wb_scheduler;

    localparam int STARVE = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_dest = '0;
    logic        src_check = 1'b0;
    logic [4:0]  src1_idx = '0;
    logic [4:0]  src2_idx = '0;
    logic        hazard_stall;
    logic        alu_wb_valid = 1'b0;
    logic [4:0]  alu_wb_idx = '0;
    logic [15:0] alu_wb_data = '0;
    logic        alu_wb_ready;
    logic        mem_wb_valid = 1'b0;
    logic [4:0]  mem_wb_idx = '0;
    logic [15:0] mem_wb_data = '0;
    logic        mem_wb_ready;
    logic        rf_we;
    logic [4:0]  rf_write_index;
    logic [15:0] rf_write_data;
    logic [31:0] busy_vec;
    logic        err_unexpected_wb;

    regfile_wb_scheduler dut (
        .clk               (clk),
        .rst               (rst),
        .issue_valid       (issue_valid),
        .issue_dest        (issue_dest),
        .src_check         (src_check),
        .src1_idx          (src1_idx),
        .src2_idx          (src2_idx),
        .hazard_stall      (hazard_stall),
        .alu_wb_valid      (alu_wb_valid),
        .alu_wb_idx        (alu_wb_idx),
        .alu_wb_data       (alu_wb_data),
        .alu_wb_ready      (alu_wb_ready),
        .mem_wb_valid      (mem_wb_valid),
        .mem_wb_idx        (mem_wb_idx),
        .mem_wb_data       (mem_wb_data),
        .mem_wb_ready      (mem_wb_ready),
        .rf_we             (rf_we),
        .rf_write_index    (rf_write_index),
        .rf_write_data     (rf_write_data),
        .busy_vec          (busy_vec),
        .err_unexpected_wb (err_unexpected_wb)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0]  idx;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];

    // Reference model state: outstanding writes per register, ALU waiting streak
    int          pend [32];
    int          streak = 0;
    bit          err_m = 1'b0;
    bit          commit_v = 1'b0;
    int          commit_idx = 0;
    bit          s_ok, s_alu_g, s_mem_g, s_alu_wait, s_acc;
    logic [4:0]  s_dest, s_widx;
    logic [15:0] s_wdata;
    bit          e_alu, e_mem, e_stall, e_dec;
    logic [31:0] e_busy;
    wr_t         mon_w;
    bit          a_done, m_done;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit iv, input logic [4:0] dest);
        issue_valid = iv;
        issue_dest  = dest;
    endtask

    // Reference model: predicts grants/stall/busy from the rules, commits at the edge
    always begin
        @(negedge clk);
        s_ok = 1'b0;
        if (rst) begin
            for (int i = 0; i < 32; i++) pend[i] = 0;
            streak   = 0;
            err_m    = 1'b0;
            commit_v = 1'b0;
            exp_q.delete();
            checkOutput("rst_rf_we", rf_we, 0);
            checkOutput("rst_busy_vec", busy_vec, 0);
            checkOutput("rst_err", err_unexpected_wb, 0);
            checkOutput("rst_wr_idx", rf_write_index, 0);
            checkOutput("rst_wr_data", rf_write_data, 0);
        end else begin
            e_alu   = alu_wb_valid && (!mem_wb_valid || streak >= STARVE);
            e_mem   = mem_wb_valid && !e_alu;
            e_stall = (src_check && (pend[src1_idx] != 0 || pend[src2_idx] != 0)) ||
                      (issue_valid && pend[issue_dest] == 3);
            e_busy  = '0;
            for (int i = 0; i < 32; i++) e_busy[i] = (pend[i] != 0);
            checkOutput("alu_ready", alu_wb_ready, e_alu);
            checkOutput("mem_ready", mem_wb_ready, e_mem);
            checkOutput("hazard_stall", hazard_stall, e_stall);
            checkOutput("busy_vec", busy_vec, e_busy);
            checkOutput("err_flag", err_unexpected_wb, err_m);
            s_ok       = 1'b1;
            s_alu_g    = e_alu;
            s_mem_g    = e_mem;
            s_alu_wait = alu_wb_valid && !e_alu;
            s_acc      = issue_valid && !e_stall;
            s_dest     = issue_dest;
            s_widx     = e_mem ? mem_wb_idx : alu_wb_idx;
            s_wdata    = e_mem ? mem_wb_data : alu_wb_data;
        end
        @(posedge clk);
        if (s_ok && !rst) begin
            e_dec = commit_v && (pend[commit_idx] > 0);
            if (commit_v && pend[commit_idx] == 0) err_m = 1'b1;
            if (e_dec) pend[commit_idx] = pend[commit_idx] - 1;
            if (s_acc) pend[s_dest] = pend[s_dest] + 1;
            streak     = s_alu_wait ? ((streak + 1 > STARVE) ? STARVE : streak + 1) : 0;
            commit_v   = s_alu_g || s_mem_g;
            commit_idx = int'(s_widx);
            if (commit_v) exp_q.push_back('{s_widx, s_wdata});
        end
    end

    // Monitor: every register-file write must match the oldest expected write
    always begin
        @(negedge clk);
        if (!rst) begin
            if (rf_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: got rf_we=1 idx=%0d data=0x%0h, expected no write at %0t",
                             rf_write_index, rf_write_data, $time);
                end else begin
                    mon_w = exp_q.pop_front();
                    checkOutput("wr_idx", rf_write_index, mon_w.idx);
                    checkOutput("wr_data", rf_write_data, mon_w.data);
                end
            end else if (exp_q.size() != 0) begin
                mon_w = exp_q.pop_front();
                checkOutput("wr_missing_we", rf_we, 1);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("init_busy", busy_vec, 0);
        checkOutput("init_we", rf_we, 0);

        // RAW stall on r5 released by an ALU writeback
        tick();
        applyStimulus(1, 5);
        tick();
        applyStimulus(0, 0);
        src_check = 1; src1_idx = 5; src2_idx = 0;
        alu_wb_valid = 1; alu_wb_idx = 5; alu_wb_data = 16'h1234;
        #1;
        checkOutput("t1_stall", hazard_stall, 1);
        checkOutput("t1_alu_ready", alu_wb_ready, 1);
        tick();
        alu_wb_valid = 0;
        #1;
        checkOutput("t1_we", rf_we, 1);
        checkOutput("t1_idx", rf_write_index, 5);
        checkOutput("t1_data", rf_write_data, 16'h1234);
        checkOutput("t1_stall_hold", hazard_stall, 1);
        tick();
        checkOutput("t1_stall_clear", hazard_stall, 0);
        src_check = 0;

        // Simultaneous requests: mem first, ALU next cycle
        applyStimulus(1, 3);
        tick();
        applyStimulus(1, 4);
        tick();
        applyStimulus(0, 0);
        mem_wb_valid = 1; mem_wb_idx = 3; mem_wb_data = 16'hAAAA;
        alu_wb_valid = 1; alu_wb_idx = 4; alu_wb_data = 16'h5555;
        #1;
        checkOutput("t2_mem_first", mem_wb_ready, 1);
        checkOutput("t2_alu_wait", alu_wb_ready, 0);
        tick();
        mem_wb_valid = 0;
        #1;
        checkOutput("t2_alu_next", alu_wb_ready, 1);
        checkOutput("t2_idx_r3", rf_write_index, 3);
        tick();
        alu_wb_valid = 0;
        #1;
        checkOutput("t2_idx_r4", rf_write_index, 4);
        checkOutput("t2_data_r4", rf_write_data, 16'h5555);
        tick();

        // Starvation: continuous mem traffic, ALU wins on its 4th waiting cycle
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 10);
            tick();
        end
        applyStimulus(1, 12);
        tick();
        applyStimulus(1, 11);
        tick();
        applyStimulus(0, 0);
        alu_wb_valid = 1; alu_wb_idx = 11; alu_wb_data = 16'h0B0B;
        mem_wb_valid = 1; mem_wb_idx = 10; mem_wb_data = 16'h1010;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("t3_mem_wins", mem_wb_ready, 1);
            checkOutput("t3_alu_loses", alu_wb_ready, 0);
            tick();
        end
        mem_wb_idx = 12; mem_wb_data = 16'h1212;
        #1;
        checkOutput("t3_alu_starved_win", alu_wb_ready, 1);
        checkOutput("t3_mem_held", mem_wb_ready, 0);
        tick();
        alu_wb_valid = 0;
        #1;
        checkOutput("t3_mem_resumes", mem_wb_ready, 1);
        tick();
        mem_wb_valid = 0;
        tick();

        // Pending saturation on r7
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 7);
            tick();
        end
        alu_wb_valid = 1; alu_wb_idx = 7; alu_wb_data = 16'h0707;
        #1;
        checkOutput("t4_full_stall", hazard_stall, 1);
        tick();
        alu_wb_valid = 0;
        #1;
        checkOutput("t4_stall_rf_we_cycle", hazard_stall, 1);
        tick();
        checkOutput("t4_stall_cleared", hazard_stall, 0);
        tick();
        applyStimulus(0, 0);
        #1;
        applyStimulus(1, 7);
        #1;
        checkOutput("t4_full_again", hazard_stall, 1);
        applyStimulus(0, 0);
        tick();

        // Increment and decrement of r8 on the same edge
        applyStimulus(1, 8);
        tick();
        applyStimulus(0, 0);
        alu_wb_valid = 1; alu_wb_idx = 8; alu_wb_data = 16'h0808;
        tick();
        alu_wb_valid = 0;
        applyStimulus(1, 8);
        tick();
        applyStimulus(0, 0);
        checkOutput("t4_r8_still_busy", busy_vec[8], 1);
        alu_wb_valid = 1; alu_wb_idx = 8; alu_wb_data = 16'h0888;
        tick();
        alu_wb_valid = 0;
        tick();
        checkOutput("t4_r8_idle", busy_vec[8], 0);

        // Unexpected writeback to idle r9
        checkOutput("t5_err_before", err_unexpected_wb, 0);
        alu_wb_valid = 1; alu_wb_idx = 9; alu_wb_data = 16'h9999;
        tick();
        alu_wb_valid = 0;
        tick();
        checkOutput("t5_err_set", err_unexpected_wb, 1);
        tick();
        tick();
        checkOutput("t5_err_sticky", err_unexpected_wb, 1);

        // Reset between handshake and register-file write
        checkOutput("t6_busy_before", busy_vec[7], 1);
        alu_wb_valid = 1; alu_wb_idx = 7; alu_wb_data = 16'h7777;
        tick();
        rst = 1;
        alu_wb_valid = 0;
        #1;
        checkOutput("t6_we_dropped", rf_we, 0);
        checkOutput("t6_busy_cleared", busy_vec, 0);
        checkOutput("t6_err_cleared", err_unexpected_wb, 0);
        tick();
        checkOutput("t6_no_write", rf_we, 0);
        rst = 0;
        tick();

        // Randomised traffic with requesters honouring the hold-until-ready rule
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            a_done = alu_wb_valid && alu_wb_ready;
            m_done = mem_wb_valid && mem_wb_ready;
            @(posedge clk);
            #1;
            if (!alu_wb_valid || a_done) begin
                alu_wb_valid = ($urandom_range(0, 2) != 0);
                alu_wb_idx   = 5'($urandom_range(0, 7));
                alu_wb_data  = 16'($urandom);
            end
            if (!mem_wb_valid || m_done) begin
                mem_wb_valid = ($urandom_range(0, 1) != 0);
                mem_wb_idx   = 5'($urandom_range(0, 7));
                mem_wb_data  = 16'($urandom);
            end
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
            src_check = 1'($urandom_range(0, 1));
            src1_idx  = 5'($urandom_range(0, 7));
            src2_idx  = 5'($urandom_range(0, 7));
        end
        tick();
        alu_wb_valid = 0;
        mem_wb_valid = 0;
        applyStimulus(0, 0);
        src_check = 0;
        repeat (4) tick();
        checkOutput("final_queue_empty", exp_q.size(), 0);
        checkOutput("final_idle_we", rf_we, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
